cpu_core_p: RTL and testbench

Parametrised multi-cycle accumulator-free CPU core, the next generation of the team's 16-bit fetch/execute CPU top. It sequences instruction fetch from an external ROM with a req/ack handshake that tolerates wait states, then performs memory-to-memory ALU, move, immediate, jump and halt operations on an external synchronous single-port-read RAM. It sits between the ROM and RAM models and the test top, replacing the fixed-width CPU top and its separate FSM/CU pair.

---
 rtl/cpu_core_p.sv | 217 +++++++++++++++++++++
 tb/tb_cpu_core_p.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_core_p.sv
// ---------------------------------------------------------------------------
// cpu_core_p
// Multi-cycle, accumulator-free CPU core. Fetches instructions from an
// external ROM over a req/ack handshake that tolerates wait states, then
// executes memory-to-memory ALU, move, load-immediate, jump and halt
// operations against an external synchronous-read RAM.
//
// Instruction format (INSTR_W = 4 + 2*RAM_AW bits):
//   [INSTR_W-1 -: 4] opcode | dest field (RAM_AW) | src field (RAM_AW)
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous, active-low reset
//   rom_req      fetch request, held until rom_ack
//   rom_addr     fetch address (= pc)
//   rom_ack      rom_data valid this cycle (only honoured while fetching)
//   rom_data     instruction word
//   ram_rd_en    read strobe; data returns on ram_rdata the next cycle
//   ram_rd_addr  read address
//   ram_rdata    read data
//   ram_we       one-cycle write strobe
//   ram_wr_addr  write address
//   ram_wdata    write data
//   pc           program counter
//   zero_flag    last ALU result (opcodes 1-6) was zero
//   halted       core is in the HALT state
//   instr_count  (only with CPU_PERF_CNT_EN) retired-instruction counter
//
// Optional feature macro: CPU_PERF_CNT_EN adds the 32-bit instr_count output.
// ---------------------------------------------------------------------------
module cpu_core_p #(
  parameter int DATA_W = 16,
  parameter int PC_W   = 8,
  parameter int RAM_AW = 6
) (
  input  logic                    clk,
  input  logic                    reset,
  output logic                    rom_req,
  output logic [PC_W-1:0]         rom_addr,
  input  logic                    rom_ack,
  input  logic [4+2*RAM_AW-1:0]   rom_data,
  output logic                    ram_rd_en,
  output logic [RAM_AW-1:0]       ram_rd_addr,
  input  logic [DATA_W-1:0]       ram_rdata,
  output logic                    ram_we,
  output logic [RAM_AW-1:0]       ram_wr_addr,
  output logic [DATA_W-1:0]       ram_wdata,
  output logic [PC_W-1:0]         pc,
  output logic                    zero_flag,
  output logic                    halted
`ifdef CPU_PERF_CNT_EN
  ,
  output logic [31:0]             instr_count
`endif
);

  localparam int INSTR_W = 4 + 2*RAM_AW;

  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_NOT  = 4'h6;
  localparam logic [3:0] OP_MOV  = 4'h7;
  localparam logic [3:0] OP_LDI  = 4'h8;
  localparam logic [3:0] OP_JMP  = 4'h9;
  localparam logic [3:0] OP_JZ   = 4'hA;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [2:0] {FETCH, DECODE, READ_S, READ_D, EXEC, HALT} stateT;

  stateT               r_state;
  stateT               w_nextState;
  logic [PC_W-1:0]     r_pc;
  logic [INSTR_W-1:0]  r_ir;
  logic [DATA_W-1:0]   r_opA;
  logic [DATA_W-1:0]   r_opB;
  logic                r_zeroFlag;

  logic [3:0]          w_opcode;
  logic [RAM_AW-1:0]   w_dest;
  logic [RAM_AW-1:0]   w_src;
  logic                w_twoOp;
  logic                w_oneOp;
  logic                w_writes;
  logic                w_setsZero;
  logic                w_takeJump;
  logic [PC_W-1:0]     w_jumpTarget;
  logic [DATA_W-1:0]   w_result;

  // Instruction field decode from the held instruction register
  assign w_opcode     = r_ir[INSTR_W-1 -: 4];
  assign w_dest       = r_ir[2*RAM_AW-1 -: RAM_AW];
  assign w_src        = r_ir[RAM_AW-1:0];
  assign w_twoOp      = (w_opcode >= OP_ADD) && (w_opcode <= OP_XOR);
  assign w_oneOp      = (w_opcode == OP_NOT) || (w_opcode == OP_MOV);
  assign w_writes     = w_twoOp || w_oneOp || (w_opcode == OP_LDI);
  assign w_setsZero   = w_twoOp || (w_opcode == OP_NOT);
  assign w_takeJump   = (w_opcode == OP_JMP) || ((w_opcode == OP_JZ) && r_zeroFlag);
  // {dest,src} is the jump target, truncated or zero-extended to the pc width
  assign w_jumpTarget = PC_W'(r_ir[2*RAM_AW-1:0]);

  assign rom_addr  = r_pc;
  assign pc        = r_pc;
  assign zero_flag = r_zeroFlag;
  assign halted    = (r_state == HALT);

  // ALU: B is mem[dest], A is mem[src]; carries and borrows are discarded
  always_comb begin
    w_result = '0;
    case (w_opcode)
      OP_ADD:  w_result = r_opB + r_opA;
      OP_SUB:  w_result = r_opB - r_opA;
      OP_AND:  w_result = r_opB & r_opA;
      OP_OR:   w_result = r_opB | r_opA;
      OP_XOR:  w_result = r_opB ^ r_opA;
      OP_NOT:  w_result = ~r_opA;
      OP_MOV:  w_result = r_opA;
      OP_LDI:  w_result = DATA_W'(w_src);
      default: w_result = '0;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= FETCH;
    else        r_state <= w_nextState;
  end

  // Next-state logic: operand reads are only sequenced for ops that need them
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      FETCH:   if (rom_ack) w_nextState = DECODE;
      DECODE: begin
        if (w_twoOp || w_oneOp)      w_nextState = READ_S;
        else if (w_opcode == OP_HALT) w_nextState = HALT;
        else                         w_nextState = EXEC;
      end
      READ_S:  w_nextState = w_twoOp ? READ_D : EXEC;
      READ_D:  w_nextState = EXEC;
      EXEC:    w_nextState = FETCH;
      HALT:    w_nextState = HALT;
      default: w_nextState = FETCH;
    endcase
  end

  // Output strobes; unused address/data outputs are held at zero
  always_comb begin
    rom_req     = 1'b0;
    ram_rd_en   = 1'b0;
    ram_rd_addr = '0;
    ram_we      = 1'b0;
    ram_wr_addr = '0;
    ram_wdata   = '0;
    case (r_state)
      // Gated by reset so the request drops while reset is held low
      FETCH:  rom_req = reset;
      DECODE: if (w_twoOp || w_oneOp) begin
        ram_rd_en   = 1'b1;
        ram_rd_addr = w_src;
      end
      READ_S: if (w_twoOp) begin
        ram_rd_en   = 1'b1;
        ram_rd_addr = w_dest;
      end
      EXEC:   if (w_writes) begin
        ram_we      = 1'b1;
        ram_wr_addr = w_dest;
        ram_wdata   = w_result;
      end
      default: ;
    endcase
  end

  // Datapath registers: instruction, pc, operands and zero flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc       <= '0;
      r_ir       <= '0;
      r_opA      <= '0;
      r_opB      <= '0;
      r_zeroFlag <= 1'b0;
    end else begin
      case (r_state)
        FETCH: if (rom_ack) begin
          r_ir <= rom_data;
          r_pc <= r_pc + PC_W'(1);
        end
        READ_S: r_opA <= ram_rdata;
        READ_D: r_opB <= ram_rdata;
        EXEC: begin
          if (w_setsZero) r_zeroFlag <= (w_result == '0);
          if (w_takeJump) r_pc <= w_jumpTarget;
        end
        default: ;
      endcase
    end
  end

`ifdef CPU_PERF_CNT_EN
  logic [31:0] r_instrCount;

  // Counts every EXEC cycle plus the transition into HALT
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_instrCount <= '0;
    end else if ((r_state == EXEC) || ((r_state == DECODE) && (w_nextState == HALT))) begin
      r_instrCount <= r_instrCount + 32'd1;
    end
  end

  assign instr_count = r_instrCount;
`endif

endmodule

// File: tb/tb_cpu_core_p.sv
// ---------------------------------------------------------------------------
// tb_cpu_core_p
// Bench for cpu_core_p. Provides a ROM responder with programmable wait
// states (driven per instruction from tasks) and a synchronous-read RAM
// model. Runs a directed program table, hand-written HALT and mid-instruction
// reset sequences, and a randomized instruction stream checked against an
// instruction-level model of the ISA.
// ---------------------------------------------------------------------------
module tb_cpu_core_p;

  logic        clk;
  logic        reset;
  logic        rom_req;
  logic [7:0]  rom_addr;
  logic        rom_ack;
  logic [15:0] rom_data;
  logic        ram_rd_en;
  logic [5:0]  ram_rd_addr;
  logic [15:0] ram_rdata;
  logic        ram_we;
  logic [5:0]  ram_wr_addr;
  logic [15:0] ram_wdata;
  logic [7:0]  pc;
  logic        zero_flag;
  logic        halted;
`ifdef CPU_PERF_CNT_EN
  logic [31:0] instrCount;
`endif

  logic [15:0] ramMem [64];

  int vectors = 0;
  int miscompares = 0;

  // Observations gathered by applyStimulus for one instruction
  logic [7:0]  obsFetch;
  int          obsReqCycles;
  int          obsWrites;
  logic [5:0]  obsWrAddr;
  logic [15:0] obsWrData;
  int          obsWrCycle;
  int          obsStop;

  typedef struct {
    logic [15:0] instr;
    int          waitCyc;
    logic [7:0]  expFetch;
    int          expStop;
    logic        expWe;
    logic [5:0]  expWrAddr;
    logic [15:0] expWrData;
    logic        expZero;
  } vecT;

  vecT dirVec [18];

  logic [15:0] refMem [64];
  logic [7:0]  refPc;
  logic        refZero;

  cpu_core_p dut (
    .clk        (clk),
    .reset      (reset),
    .rom_req    (rom_req),
    .rom_addr   (rom_addr),
    .rom_ack    (rom_ack),
    .rom_data   (rom_data),
    .ram_rd_en  (ram_rd_en),
    .ram_rd_addr(ram_rd_addr),
    .ram_rdata  (ram_rdata),
    .ram_we     (ram_we),
    .ram_wr_addr(ram_wr_addr),
    .ram_wdata  (ram_wdata),
    .pc         (pc),
    .zero_flag  (zero_flag),
    .halted     (halted)
`ifdef CPU_PERF_CNT_EN
    ,
    .instr_count(instrCount)
`endif
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous single-port-read RAM model
  always @(posedge clk) begin
    if (ram_we)    ramMem[ram_wr_addr] <= ram_wdata;
    if (ram_rd_en) ram_rdata <= ramMem[ram_rd_addr];
  end

  // Hard time limit so the bench can never hang
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got no completion, required finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [15:0] enc(input logic [3:0] op, input logic [5:0] d, input logic [5:0] s);
    return {op, d, s};
  endfunction

  // Single comparison: counts it and reports a failure line on mismatch
  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
    end
  endtask

  // Serves one fetch with waitCyc ROM wait states, then watches the core
  // until the next fetch request or halt. Cycle 1 is the ack cycle.
  task automatic applyStimulus(input logic [15:0] instr, input int waitCyc);
    int n;
    int cycle;
    obsFetch     = '0;
    obsReqCycles = 0;
    obsWrites    = 0;
    obsWrAddr    = '0;
    obsWrData    = '0;
    obsWrCycle   = 0;
    obsStop      = 0;
    n = 0;
    while (!rom_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    obsFetch = rom_addr;
    for (int i = 0; i <= waitCyc; i++) begin
      if (rom_req && rom_addr == obsFetch) obsReqCycles++;
      if (i == waitCyc) begin
        rom_ack  = 1'b1;
        rom_data = instr;
      end
      @(negedge clk);
    end
    rom_ack  = 1'b0;
    rom_data = '0;
    cycle = 2;
    while (cycle < 24) begin
      if (ram_we) begin
        obsWrites++;
        obsWrAddr  = ram_wr_addr;
        obsWrData  = ram_wdata;
        obsWrCycle = cycle;
      end
      if (rom_req || halted) begin
        obsStop = cycle;
        break;
      end
      @(negedge clk);
      cycle++;
    end
  endtask

  initial begin
    int bad;
    reset    = 1'b0;
    rom_ack  = 1'b0;
    rom_data = '0;

    // Directed program with hand-computed expectations
    dirVec[0]  = '{enc(4'h8, 6'd1, 6'd5),    0, 8'h00, 4, 1'b1, 6'd1, 16'h0005, 1'b0};
    dirVec[1]  = '{enc(4'h8, 6'd2, 6'd4),    0, 8'h01, 4, 1'b1, 6'd2, 16'h0004, 1'b0};
    dirVec[2]  = '{enc(4'h6, 6'd2, 6'd2),    0, 8'h02, 5, 1'b1, 6'd2, 16'hFFFB, 1'b0};
    dirVec[3]  = '{enc(4'h1, 6'd2, 6'd1),    0, 8'h03, 6, 1'b1, 6'd2, 16'h0000, 1'b1};
    dirVec[4]  = '{enc(4'hA, 6'd0, 6'h20),   3, 8'h04, 4, 1'b0, 6'd0, 16'h0000, 1'b1};
    dirVec[5]  = '{enc(4'h8, 6'd3, 6'd7),    0, 8'h20, 4, 1'b1, 6'd3, 16'h0007, 1'b1};
    dirVec[6]  = '{enc(4'h2, 6'd3, 6'd3),    1, 8'h21, 6, 1'b1, 6'd3, 16'h0000, 1'b1};
    dirVec[7]  = '{enc(4'h4, 6'd3, 6'd1),    0, 8'h22, 6, 1'b1, 6'd3, 16'h0005, 1'b0};
    dirVec[8]  = '{enc(4'hA, 6'd0, 6'h10),   0, 8'h23, 4, 1'b0, 6'd0, 16'h0000, 1'b0};
    dirVec[9]  = '{enc(4'h5, 6'd1, 6'd3),    2, 8'h24, 6, 1'b1, 6'd1, 16'h0000, 1'b1};
    dirVec[10] = '{enc(4'h7, 6'd4, 6'd3),    0, 8'h25, 5, 1'b1, 6'd4, 16'h0005, 1'b1};
    dirVec[11] = '{enc(4'h3, 6'd4, 6'd3),    0, 8'h26, 6, 1'b1, 6'd4, 16'h0005, 1'b0};
    dirVec[12] = '{enc(4'h0, 6'd0, 6'd0),    0, 8'h27, 4, 1'b0, 6'd0, 16'h0000, 1'b0};
    dirVec[13] = '{enc(4'hC, 6'd5, 6'd5),    0, 8'h28, 4, 1'b0, 6'd0, 16'h0000, 1'b0};
    dirVec[14] = '{enc(4'h9, 6'h23, 6'h3F),  0, 8'h29, 4, 1'b0, 6'd0, 16'h0000, 1'b0};
    dirVec[15] = '{enc(4'h0, 6'd0, 6'd0),    1, 8'hFF, 4, 1'b0, 6'd0, 16'h0000, 1'b0};
    dirVec[16] = '{enc(4'h2, 6'd1, 6'd3),    0, 8'h00, 6, 1'b1, 6'd1, 16'hFFFB, 1'b0};
    dirVec[17] = '{enc(4'h1, 6'd1, 6'd1),    0, 8'h01, 6, 1'b1, 6'd1, 16'hFFF6, 1'b0};

    for (int i = 0; i < 64; i++) ramMem[i] <= 16'h0000;

    repeat (3) @(negedge clk);

    // Outputs while reset is held
    checkOutput("reset.rom_req",     rom_req,     0);
    checkOutput("reset.ram_rd_en",   ram_rd_en,   0);
    checkOutput("reset.ram_we",      ram_we,      0);
    checkOutput("reset.pc",          pc,          0);
    checkOutput("reset.rom_addr",    rom_addr,    0);
    checkOutput("reset.zero_flag",   zero_flag,   0);
    checkOutput("reset.halted",      halted,      0);
    checkOutput("reset.addrData",    {ram_rd_addr, ram_wr_addr, ram_wdata}, 0);
`ifdef CPU_PERF_CNT_EN
    checkOutput("reset.instr_count", instrCount,  0);
`endif

    reset = 1'b1;
    #1;
    checkOutput("release.rom_req", rom_req, 1);

    for (int i = 0; i < 18; i++) begin
      applyStimulus(dirVec[i].instr, dirVec[i].waitCyc);
      checkOutput($sformatf("dir%0d.fetch", i),   obsFetch,     dirVec[i].expFetch);
      checkOutput($sformatf("dir%0d.reqHold", i), obsReqCycles, dirVec[i].waitCyc + 1);
      checkOutput($sformatf("dir%0d.latency", i), obsStop,      dirVec[i].expStop);
      checkOutput($sformatf("dir%0d.writes", i),  obsWrites,    dirVec[i].expWe);
      if (dirVec[i].expWe) begin
        checkOutput($sformatf("dir%0d.wrAddr", i),  obsWrAddr,  dirVec[i].expWrAddr);
        checkOutput($sformatf("dir%0d.wrData", i),  obsWrData,  dirVec[i].expWrData);
        checkOutput($sformatf("dir%0d.wrCycle", i), obsWrCycle, dirVec[i].expStop - 1);
      end
      checkOutput($sformatf("dir%0d.zero", i), zero_flag, dirVec[i].expZero);
    end

    // HALT: halted the cycle after decode, then quiet with pc frozen
    applyStimulus(16'hF000, 0);
    checkOutput("halt.fetch",   obsFetch,  8'h02);
    checkOutput("halt.latency", obsStop,   3);
    checkOutput("halt.writes",  obsWrites, 0);
    checkOutput("halt.halted",  halted,    1);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rom_req || !halted || pc != 8'h03 || ram_we || ram_rd_en) bad++;
    end
    checkOutput("halt.quietCycles", bad, 0);
`ifdef CPU_PERF_CNT_EN
    checkOutput("halt.instr_count", instrCount, 19);
`endif

    // Reset asserted during READ_D of a SUB must abort with no write
    reset = 1'b0;
    ramMem[5] <= 16'h1234;
    ramMem[6] <= 16'h0034;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    rom_ack  = 1'b1;
    rom_data = enc(4'h2, 6'd5, 6'd6);
    @(negedge clk);
    rom_ack  = 1'b0;
    rom_data = '0;
    checkOutput("sub.decodeRead", {ram_rd_en, ram_rd_addr}, {1'b1, 6'd6});
    @(negedge clk);
    checkOutput("sub.readSRead",  {ram_rd_en, ram_rd_addr}, {1'b1, 6'd5});
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("midReset.strobes", {rom_req, ram_we, ram_rd_en}, 0);
    checkOutput("midReset.pc",      pc, 0);
    bad = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if (ram_we) bad++;
    end
    checkOutput("midReset.noWe",   bad, 0);
    checkOutput("midReset.mem5",   ramMem[5], 16'h1234);
`ifdef CPU_PERF_CNT_EN
    checkOutput("midReset.instr_count", instrCount, 0);
`endif

    // Random memory image for the randomized stream, loaded under reset
    for (int i = 0; i < 64; i++) begin
      logic [15:0] v;
      v = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 3)) : 16'($urandom);
      ramMem[i] <= v;
      refMem[i] = v;
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    checkOutput("release2.rom_req",  rom_req,  1);
    checkOutput("release2.rom_addr", rom_addr, 0);
    refPc   = 8'h00;
    refZero = 1'b0;

    // Randomized stream against the instruction-level model
    for (int k = 0; k < 150; k++) begin
      logic [3:0]  op;
      logic [5:0]  d;
      logic [5:0]  s;
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] res;
      logic [11:0] target;
      logic [7:0]  expFetch;
      int          reads;
      logic        writes;
      int          waitCyc;
      op      = 4'($urandom_range(0, 14));
      d       = 6'($urandom);
      s       = 6'($urandom);
      waitCyc = $urandom_range(0, 2);
      a       = refMem[s];
      b       = refMem[d];
      res     = '0;
      reads   = 0;
      writes  = 1'b1;
      case (op)
        4'h1: begin res = b + a; reads = 2; end
        4'h2: begin res = b - a; reads = 2; end
        4'h3: begin res = b & a; reads = 2; end
        4'h4: begin res = b | a; reads = 2; end
        4'h5: begin res = b ^ a; reads = 2; end
        4'h6: begin res = ~a;    reads = 1; end
        4'h7: begin res = a;     reads = 1; end
        4'h8: res = {10'd0, s};
        default: writes = 1'b0;
      endcase
      expFetch = refPc;
      refPc    = refPc + 8'd1;
      target   = {d, s};
      if (op == 4'h9 || (op == 4'hA && refZero)) refPc = target[7:0];
      if (op >= 4'h1 && op <= 4'h6) refZero = (res == 16'h0000);

      applyStimulus({op, d, s}, waitCyc);
      checkOutput($sformatf("rnd%0d.fetch", k),   obsFetch,     expFetch);
      checkOutput($sformatf("rnd%0d.reqHold", k), obsReqCycles, waitCyc + 1);
      checkOutput($sformatf("rnd%0d.latency", k), obsStop,      4 + reads);
      checkOutput($sformatf("rnd%0d.writes", k),  obsWrites,    writes);
      if (writes) begin
        checkOutput($sformatf("rnd%0d.wr", k), {obsWrAddr, obsWrData}, {d, res});
        refMem[d] = res;
      end
      checkOutput($sformatf("rnd%0d.zero", k), zero_flag, refZero);
    end
    checkOutput("rnd.finalAddr", rom_addr, refPc);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
